// File: rtl/sram_controller.sv
// Sequences one 32-bit CPU load/store as two 16-bit SRAM accesses (low half, then high half).
// The pipeline is stalled through ready while a transaction is in flight.
module sram_controller #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned HALF_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic        sram_we_n,
    output logic        sram_oe_n,
    output logic        sram_ce_n,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in
);

    localparam logic [3:0] CntLast = 4'(HALF_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLow,
        StHigh,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        is_write_q, is_write_d;
    logic [16:0] index_q, index_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] rd_low_q, rd_low_d;
    logic [31:0] read_data_q, read_data_d;

    // Only the low 19 bits of the offset can reach the 17-bit word index.
    logic [18:0] offset;
    logic        cnt_last;
    logic        unused_bits;

    assign offset      = address[18:0] - 19'(BASE_ADDR);
    assign cnt_last    = (cnt_q == CntLast);
    assign unused_bits = ^{address[31:19], offset[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            is_write_q  <= 1'b0;
            index_q     <= '0;
            wdata_q     <= '0;
            rd_low_q    <= '0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_write_q  <= is_write_d;
            index_q     <= index_d;
            wdata_q     <= wdata_d;
            rd_low_q    <= rd_low_d;
            read_data_q <= read_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_write_d  = is_write_q;
        index_d     = index_q;
        wdata_d     = wdata_q;
        rd_low_d    = rd_low_q;
        read_data_d = read_data_q;

        case (state_q)
            StIdle: begin
                if (mem_read || mem_write) begin
                    state_d    = StLow;
                    cnt_d      = '0;
                    is_write_d = mem_write;
                    index_d    = offset[18:2];
                    wdata_d    = write_data;
                end
            end
            StLow: begin
                if (cnt_last) begin
                    state_d = StHigh;
                    cnt_d   = '0;
                    if (!is_write_q) begin
                        rd_low_d = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StHigh: begin
                if (cnt_last) begin
                    state_d = StDone;
                    cnt_d   = '0;
                    if (!is_write_q) begin
                        read_data_d = {sram_dq_in, rd_low_q};
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        sram_ce_n   = 1'b1;
        sram_we_n   = 1'b1;
        sram_oe_n   = 1'b1;
        sram_dq_oe  = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;

        if (state_q == StLow || state_q == StHigh) begin
            sram_ce_n = 1'b0;
            sram_addr = {index_q, (state_q == StHigh)};
            if (is_write_q) begin
                sram_dq_oe  = 1'b1;
                sram_dq_out = (state_q == StHigh) ? wdata_q[31:16] : wdata_q[15:0];
                // Release we_n one cycle early so the address is stable on its rising edge.
                sram_we_n   = cnt_last;
            end else begin
                sram_oe_n = 1'b0;
            end
        end
    end

    assign ready     = (state_q == StDone) ||
                       ((state_q == StIdle) && !mem_read && !mem_write);
    assign read_data = read_data_q;

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: directed vector table, corner-case sequences and
// random transactions checked against a word-level memory model.
module tb_sram_controller;

    localparam int unsigned Base = 1024;
    localparam int unsigned Hc   = 2;
    localparam int unsigned Lat  = 1 + 2 * Hc;

    logic        clk;
    logic        rst;
    logic        mem_read, mem_write;
    logic [31:0] address, write_data, read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic        sram_we_n, sram_oe_n, sram_ce_n, sram_dq_oe;
    logic [15:0] sram_dq_out, sram_dq_in;

    // Second instance with longer half-accesses.
    logic        r4, w4, rdy4, we4, oe4, ce4, dqoe4;
    logic [31:0] a4, wd4, rdd4;
    logic [17:0] addr4;
    logic [15:0] dqo4, dqi4;

    int n_checks = 0;
    int n_fail   = 0;

    sram_controller #(.BASE_ADDR(Base), .HALF_CYCLES(Hc)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .address(address), .write_data(write_data), .read_data(read_data), .ready(ready),
        .sram_addr(sram_addr), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
        .sram_ce_n(sram_ce_n), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in)
    );

    sram_controller #(.BASE_ADDR(Base), .HALF_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .mem_read(r4), .mem_write(w4),
        .address(a4), .write_data(wd4), .read_data(rdd4), .ready(rdy4),
        .sram_addr(addr4), .sram_we_n(we4), .sram_oe_n(oe4),
        .sram_ce_n(ce4), .sram_dq_out(dqo4), .sram_dq_oe(dqoe4),
        .sram_dq_in(dqi4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Unwritten SRAM halves read back a fixed address-derived pattern.
    function automatic logic [15:0] init_half(input int unsigned a);
        return 16'(a * 32'h3b1) ^ 16'h5a5a;
    endfunction

    logic [15:0] sram [0:1023];
    bit          written [0:1023];

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            sram[sram_addr[9:0]]    <= sram_dq_out;
            written[sram_addr[9:0]] <= 1'b1;
        end
    end

    always_comb begin
        sram_dq_in = written[sram_addr[9:0]] ? sram[sram_addr[9:0]]
                                             : init_half(32'(sram_addr[9:0]));
    end

    always @(posedge clk) begin
        if (rst && !sram_ce_n) begin
            check("addr_in_range", 32'(sram_addr[17:10]), 32'd0);
            if (!sram_we_n) check("we_needs_dq_oe", 32'(sram_dq_oe), 32'd1);
            if (!sram_we_n) check("we_oe_exclusive", 32'(sram_oe_n), 32'd1);
        end
    end

    assign dqi4 = addr4[15:0] + 16'h1000;

    // Word-level reference model: the memory as 32-bit words indexed by word number.
    logic [31:0] model_words [int unsigned];
    logic [31:0] exp_rd;

    function automatic logic [31:0] model_read(input int unsigned k);
        if (model_words.exists(k)) return model_words[k];
        return {init_half(2 * k + 1), init_half(2 * k)};
    endfunction

    task automatic do_txn(input bit rd, input bit wr, input int unsigned k,
                          input logic [31:0] wd, output int lat);
        @(posedge clk); #1;
        mem_read   = rd;
        mem_write  = wr;
        address    = Base + 4 * k;
        write_data = wd;
        @(negedge clk);
        check("ready_low_at_request", 32'(ready), 32'd0);
        @(posedge clk); #1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        address    = $urandom;
        write_data = $urandom;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (ready) begin
                lat = c;
                break;
            end
        end
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        int unsigned k;
        logic [31:0] wd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [5];

    initial begin : main
        int          lat;
        logic [11:0] rmask;
        bit          we_low;

        rst = 1'b1;
        mem_read = 0; mem_write = 0; address = 0; write_data = 0;
        r4 = 0; w4 = 0; a4 = 0; wd4 = 0;
        #2 rst = 1'b0;
        #1;
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_read_data", read_data, 32'd0);
        check("reset_strobes", {29'd0, sram_ce_n, sram_we_n, sram_oe_n}, 32'h7);
        check("reset_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("reset_addr", 32'(sram_addr), 32'd0);
        check("reset_dq_out", 32'(sram_dq_out), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        vecs[0] = '{rd: 0, wr: 1, k: 2, wd: 32'h12345678, exp_rd: 32'h0};
        vecs[1] = '{rd: 1, wr: 0, k: 2, wd: 32'h0,        exp_rd: 32'h12345678};
        vecs[2] = '{rd: 1, wr: 1, k: 0, wd: 32'hCAFEBABE, exp_rd: 32'h12345678};
        vecs[3] = '{rd: 1, wr: 0, k: 0, wd: 32'h0,        exp_rd: 32'hCAFEBABE};
        vecs[4] = '{rd: 1, wr: 0, k: 5, wd: 32'h0,
                    exp_rd: {init_half(11), init_half(10)}};

        for (int i = 0; i < 5; i++) begin
            do_txn(vecs[i].rd, vecs[i].wr, vecs[i].k, vecs[i].wd, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(Lat));
            check($sformatf("vec%0d_read_data", i), read_data, vecs[i].exp_rd);
            if (vecs[i].wr) model_words[vecs[i].k] = vecs[i].wd;
        end
        check("sram4_low_half", 32'(sram[4]), 32'h5678);
        check("sram5_high_half", 32'(sram[5]), 32'h1234);
        check("sram0_low_half", 32'(sram[0]), 32'hBABE);
        check("sram1_high_half", 32'(sram[1]), 32'hCAFE);
        repeat (3) @(negedge clk);
        check("read_data_held_idle", read_data, vecs[4].exp_rd);

        // Read held high across two addresses: two back-to-back transactions.
        @(posedge clk); #1;
        mem_read = 1'b1;
        address  = Base + 8;
        rmask    = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            rmask[c] = ready;
            if (c == 5)  check("b2b_first_data", read_data, model_read(2));
            if (c == 11) check("b2b_second_data", read_data, model_read(0));
            @(posedge clk); #1;
            if (c == 5)  address = Base;
            if (c == 11) mem_read = 1'b0;
        end
        check("b2b_ready_pattern", 32'(rmask), 32'h820);

        exp_rd = read_data;
        for (int i = 0; i < 40; i++) begin
            int unsigned op, k;
            logic [31:0] wd;
            op = $urandom_range(0, 2);
            k  = $urandom_range(0, 255);
            wd = $urandom;
            do_txn(op != 1, op != 0, k, wd, lat);
            if (op != 0) model_words[k] = wd;
            else         exp_rd = model_read(k);
            check("rand_latency", 32'(lat), 32'(Lat));
            check("rand_read_data", read_data, exp_rd);
        end
        foreach (model_words[k]) begin
            check("model_sweep", {sram[2 * k + 1], sram[2 * k]}, model_words[k]);
        end

        // Reset in the first HIGH cycle of a write aborts it before the high half lands.
        @(posedge clk); #1;
        mem_write  = 1'b1;
        address    = Base + 4 * 300;
        write_data = 32'hDEADBEEF;
        @(posedge clk); #1;
        mem_write = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("we_active_before_reset", 32'(sram_we_n), 32'd0);
        rst = 1'b0;
        #1;
        check("abort_strobes", {29'd0, sram_ce_n, sram_we_n, sram_oe_n}, 32'h7);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("abort_addr", 32'(sram_addr), 32'd0);
        check("abort_read_data", read_data, 32'd0);
        @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("abort_low_written", 32'(sram[600]), 32'hBEEF);
        check("abort_high_untouched", 32'(written[601]), 32'd0);

        do_txn(1, 0, 300, 32'h0, lat);
        check("post_reset_latency", 32'(lat), 32'(Lat));
        check("post_reset_read", read_data, {init_half(601), 16'hBEEF});

        // HALF_CYCLES = 4 read of word 3: halves 6 and 7.
        @(posedge clk); #1;
        r4 = 1'b1;
        a4 = Base + 12;
        lat = -1;
        we_low = 1'b0;
        for (int c = 0; c <= 20; c++) begin
            @(negedge clk);
            if (!we4) we_low = 1'b1;
            if (rdy4) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
            r4 = 1'b0;
        end
        check("hc4_latency", 32'(lat), 32'd9);
        check("hc4_read_data", rdd4, 32'h10071006);
        check("hc4_we_never_low", 32'(we_low), 32'd0);
        check("hc4_done_idle_bus", {12'd0, addr4, dqoe4, ce4}, 32'h1);
        check("hc4_done_idle_data", {15'd0, dqo4, oe4}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter BASE_ADDR, default 1024: data-memory base address subtracted from the CPU byte address.
REQ-002 Parameter HALF_CYCLES, default 2, legal range 2..15: clock cycles spent on each 16-bit half access.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-low reset.
REQ-005 Port mem_read, input, 1: read request from the decoded control word (MEM-stage copy).
REQ-006 Port mem_write, input, 1: write request from the decoded control word (MEM-stage copy).
REQ-007 Port address, input, 32: CPU byte address, word aligned.
REQ-008 Port write_data, input, 32: store data.
REQ-009 Port read_data, output, 32: load result, registered.
REQ-010 Port ready, output, 1: high when no transaction is pending; low freezes the pipeline.
REQ-011 Port sram_addr, output, 18: SRAM 16-bit-word address.
REQ-012 Port sram_we_n / sram_oe_n / sram_ce_n, output, 1 each: active-low SRAM strobes.
REQ-013 Port sram_dq_out, output, 16: data driven to SRAM.
REQ-014 Port sram_dq_oe, output, 1: tristate enable for sram_dq_out (top level builds the inout).
REQ-015 Port sram_dq_in, input, 16: data sampled from SRAM.

Function
REQ-016 States: IDLE, LOW, HIGH, DONE; a cycle counter cnt counts 0..HALF_CYCLES-1 inside LOW and HIGH.
REQ-017 IDLE with mem_read|mem_write high: latch op (write if mem_write=1, else read), word index = (address - BASE_ADDR) >> 2 (17 bits, modulo), and write_data; next state LOW, cnt=0.
REQ-018 mem_read and mem_write both high: treated as a write; read_data unchanged.
REQ-019 LOW: sram_addr = {index, 1'b0}; advances to HIGH with cnt=0 when cnt = HALF_CYCLES-1.
REQ-020 HIGH: sram_addr = {index, 1'b1}; advances to DONE when cnt = HALF_CYCLES-1.
REQ-021 DONE: lasts exactly one cycle, then IDLE; a request present in that following IDLE cycle starts a new transaction (back-to-back allowed).
REQ-022 ready = 1 in DONE, or in IDLE with mem_read=mem_write=0; 0 otherwise (combinational from state and requests).
REQ-023 Latency: request first seen in cycle 0 -> ready high in cycle 1 + 2*HALF_CYCLES (cycle 5 at default).
REQ-024 Read: sram_ce_n=0, sram_oe_n=0, sram_dq_oe=0 in LOW/HIGH; sram_dq_in captured at the last LOW cycle into bits 15:0 and at the last HIGH cycle into bits 31:16.
REQ-025 read_data updates only at completion of a read, is valid from DONE, and holds until the next read completes.
REQ-026 Write: sram_ce_n=0, sram_dq_oe=1 in LOW/HIGH; sram_dq_out = data[15:0] in LOW, data[31:16] in HIGH; sram_we_n=0 in all but the last cycle of each phase (address stable while we_n rises).
REQ-027 IDLE/DONE: sram_ce_n=sram_we_n=sram_oe_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
REQ-028 Requests are sampled only in IDLE; changes to mem_read, mem_write, address or write_data during LOW/HIGH/DONE have no effect on the active transaction.

Reset
REQ-029 rst=0 forces IDLE, cnt=0, read_data=0, all strobes high, sram_dq_oe=0, sram_addr=0, sram_dq_out=0, immediately and without waiting for clk.
REQ-030 Reset during LOW or HIGH aborts the transaction: no further SRAM strobes; read_data stays 0.
REQ-031 After rst returns high, the first rising edge with a request starts a transaction normally.

Verification
REQ-032 Write 0x12345678 to address 1032 -> sram_addr 4 gets 0x5678, then 5 gets 0x1234; ready low cycles 0-4, high cycle 5.
REQ-033 Read 1032 with the SRAM model holding those halves -> read_data 0x12345678 in cycle 5, held while idle.
REQ-034 mem_read held high across two different addresses -> two transactions, ready high only in cycles 5 and 11.
REQ-035 mem_read=mem_write=1, data 0xCAFEBABE at 1024 -> sram_addr 0/1 written 0xBABE/0xCAFE; read_data unchanged.
REQ-036 rst pulsed low in cycle 3 of a write -> strobes high and ready=1 asynchronously; SRAM half at address 1 never written.
REQ-037 HALF_CYCLES=4, read -> ready high in cycle 9; sram_we_n stays 1 throughout.
